// File: rtl/mux16_pkg.sv
// Shared types and widths for the 16-way mux arbiter slice.
// Imported by the datapath mux and by the round-robin arbiter top.
package mux16_pkg;

    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int HCNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Result of a round-robin winner search.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/mux16to1.sv
// Single-bit 16:1 multiplexer datapath.
// Purely combinational; the arbiter owns its select.
module mux16to1
    import mux16_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = in[sel];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter owning the mux16to1 select, with a one-hot registered grant
// and an optional maximum hold time that hands the mux on when others are waiting.
module mux16_rr_arbiter
    import mux16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             dout,
    output logic             preempt
);

    // Rotate so that start sits at bit 0, take the lowest set bit, then rotate back.
    function automatic pick_t find_first(input logic [N_REQ-1:0] vec,
                                         input logic [SEL_W-1:0] start);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        pick_t              p;
        dbl = {vec, vec} >> start;
        rot = dbl[N_REQ-1:0];
        p   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                p.found = 1'b1;
                p.idx   = SEL_W'(i) + start;
            end
        end
        return p;
    endfunction

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                valid_q, valid_d;
    logic                preempt_q, preempt_d;

    logic [N_REQ-1:0]    others;
    logic                at_limit;
    logic                rel_a;
    logic                rel_b;
    pick_t               pick_idle;
    pick_t               pick_rel;
    logic                mux_y;

    assign others    = req & ~(N_REQ'(1) << sel_q);
    assign at_limit  = (MAX_HOLD != 0) && (hcnt_q == HCNT_W'(MAX_HOLD - 1));
    assign rel_a     = ~req[sel_q];
    assign rel_b     = at_limit && (|others);
    assign pick_idle = find_first(req, ptr_q);
    assign pick_rel  = find_first(others, sel_q + SEL_W'(1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d = GRANT;
                    grant_d = N_REQ'(1) << pick_idle.idx;
                    sel_d   = pick_idle.idx;
                    valid_d = 1'b1;
                    hcnt_d  = '0;
                end
            end
            GRANT: begin
                if (rel_a || rel_b) begin
                    ptr_d     = sel_q + SEL_W'(1);
                    preempt_d = rel_b;
                    hcnt_d    = '0;
                    if (pick_rel.found) begin
                        grant_d = N_REQ'(1) << pick_rel.idx;
                        sel_d   = pick_rel.idx;
                    end else begin
                        // sel deliberately keeps its last value while idle.
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (at_limit) begin
                    // Sole requester at the limit: restart the window instead of preempting.
                    hcnt_d = '0;
                end else if (hcnt_q != '1) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    mux16to1 u_mux (
        .in  (din),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;
    assign dout    = valid_q & mux_y;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter (MAX_HOLD=8 and an unlimited-hold
// instance sharing the same stimulus).
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] din;

    logic [15:0] grant,   grant0;
    logic [3:0]  sel,     sel0;
    logic        valid,   valid0;
    logic        dout,    dout0;
    logic        preempt, preempt0;

    int n_checks = 0;
    int n_fail   = 0;

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .grant   (grant),
        .sel     (sel),
        .valid   (valid),
        .dout    (dout),
        .preempt (preempt)
    );

    mux16_rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .grant   (grant0),
        .sel     (sel0),
        .valid   (valid0),
        .dout    (dout0),
        .preempt (preempt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},   32'(grant),   32'h0);
        check({tag, "_sel"},     32'(sel),     32'h0);
        check({tag, "_valid"},   32'(valid),   32'h0);
        check({tag, "_dout"},    32'(dout),    32'h0);
        check({tag, "_preempt"}, 32'(preempt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every requester asking.
        rst = 1'b1;
        req = 16'hFFFF;
        din = 16'hA5A5;
        #1;
        check_all_zero("rst_t0");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("rst_hold");
            check("rst_hold_valid0", 32'(valid0), 32'h0);
        end

        // Rotation with all requesting: 8 cycles per requester, preempt on every step.
        rst = 1'b0;
        tick();
        for (int s = 0; s < 17; s++) begin
            for (int c = 0; c < 8; c++) begin
                check("rot_sel",     32'(sel),     32'(s % 16));
                check("rot_grant",   32'(grant),   32'(16'h1 << (s % 16)));
                check("rot_valid",   32'(valid),   32'h1);
                check("rot_preempt", 32'(preempt), 32'((c == 0 && s != 0) ? 1 : 0));
                check("rot_nolimit_sel",     32'(sel0),     32'h0);
                check("rot_nolimit_preempt", 32'(preempt0), 32'h0);
                tick();
            end
        end
        req = 16'h0000;
        tick();
        check("rot_end_valid", 32'(valid), 32'h0);
        check("rot_end_grant", 32'(grant), 32'h0);

        // Single request: bit 12 of 16'h3f0a is 1.
        din = 16'h3f0a;
        req = 16'h1000;
        tick();
        check("single_grant", 32'(grant), 32'h1000);
        check("single_sel",   32'(sel),   32'hc);
        check("single_valid", 32'(valid), 32'h1);
        check("single_dout",  32'(dout),  32'h1);
        din = 16'h2f0a;
        #1;
        check("single_dout_comb", 32'(dout), 32'h0);
        din = 16'h3f0a;
        #1;
        check("single_dout_comb1", 32'(dout), 32'h1);
        req = 16'h0000;
        tick();
        check("single_drop_valid", 32'(valid), 32'h0);
        check("single_drop_dout",  32'(dout),  32'h0);
        check("single_drop_grant", 32'(grant), 32'h0);
        check("single_drop_sel",   32'(sel),   32'hc);

        // Handoff on release: ptr is 13, so bit 0 wins first, then bit 1 with no gap.
        req = 16'h0003;
        tick();
        check("handoff_sel0",  32'(sel),   32'h0);
        check("handoff_grant0", 32'(grant), 32'h0001);
        req = 16'h0002;
        tick();
        check("handoff_sel1",    32'(sel),     32'h1);
        check("handoff_grant1",  32'(grant),   32'h0002);
        check("handoff_valid",   32'(valid),   32'h1);
        check("handoff_preempt", 32'(preempt), 32'h0);
        req = 16'h0000;
        tick();
        check("handoff_idle", 32'(valid), 32'h0);

        // Sole requester: hold counter reloads at the limit, no preemption.
        req = 16'h0100;
        tick();
        for (int i = 0; i < 30; i++) begin
            check("sole_sel",     32'(sel),     32'h8);
            check("sole_valid",   32'(valid),   32'h1);
            check("sole_preempt", 32'(preempt), 32'h0);
            check("sole_nolimit_sel", 32'(sel0), 32'h8);
            tick();
        end
        // Hold count is now 6: one more cycle at 8, then preempted to 9.
        req = 16'h0300;
        tick();
        check("late_sel_a",     32'(sel),     32'h8);
        check("late_preempt_a", 32'(preempt), 32'h0);
        tick();
        check("late_sel_b",     32'(sel),     32'h9);
        check("late_preempt_b", 32'(preempt), 32'h1);
        check("late_nolimit_sel", 32'(sel0), 32'h8);
        tick();
        check("late_sel_c",     32'(sel),     32'h9);
        check("late_preempt_c", 32'(preempt), 32'h0);
        req = 16'h0000;
        tick();

        // Build ptr=5 via a release from 4 to 5, then reset mid-grant.
        req = 16'h0010;
        tick();
        check("pre_rst_sel4", 32'(sel), 32'h4);
        req = 16'h0020;
        tick();
        check("pre_rst_sel5",   32'(sel),   32'h5);
        check("pre_rst_valid",  32'(valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        req = 16'h0022;
        tick();
        check("post_rst_sel_a", 32'(sel), 32'h1);
        tick();
        check("post_rst_sel",   32'(sel),   32'h1);
        check("post_rst_grant", 32'(grant), 32'h0002);
        check("post_rst_valid", 32'(valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares the 16:1 single-bit multiplexer between 16 requesters. It owns the select of the mux16to1 datapath and issues a one-hot grant. It enforces a configurable maximum hold time so a single requester cannot starve the others. It sits between requesting agents and the shared mux output, and forwards the granted requester's data bit to `dout`.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester is waiting.
  - Legal range 0..255.
  - 0 = unlimited hold; preemption disabled.

Ports:
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `req`  in  16  — request vector; bit i = requester i wants the mux.
- `din`  in  16  — data bits, one per requester; feeds mux16to1 `in`.
- `grant`  out  16  — one-hot registered grant; all-zero when idle.
- `sel`  out  4  — registered index of the granted requester; drives mux16to1 `sel`.
- `valid`  out  1  — registered; high while a grant is active.
- `dout`  out  1  — `din[sel]` when `valid`, else 0.
- `preempt`  out  1  — registered one-cycle pulse when a grant is removed by `MAX_HOLD`.

## Operation

- Internal state:
  - FSM state: IDLE or GRANT.
  - 4-bit priority pointer `ptr`.
  - 8-bit hold counter `hcnt`.
- Winner search (combinational): first set bit of a masked `req`, scanning upward from a start index with wrap 15→0.
- IDLE:
  - If `req` == 0: stay in IDLE.
  - Else: search from `ptr`. Next cycle: `grant`/`sel` load the winner, `valid`=1, `hcnt`=0, state→GRANT.
- GRANT, no release: hold the grant; `hcnt` increments and saturates at 255.
- Release conditions (either one):
  - (a) `req[sel]`==0.
  - (b) `MAX_HOLD`≠0, `hcnt`==`MAX_HOLD`−1, and another request is pending (`req` with bit `sel` masked ≠ 0).
- Sole requester at the limit (another request not pending): no release; `hcnt` reloads to 0; no `preempt`.
- On release:
  - `ptr` ← `sel`+1 mod 16.
  - Search `req` with bit `sel` masked, starting at `sel`+1.
  - Winner found: grant switches to it on the next edge, `hcnt`=0, no idle gap.
  - No winner: state→IDLE, `grant`=0, `valid`=0. `sel` keeps its last value.
- `preempt`=1 for exactly the cycle after a release caused by (b), including when (a) and (b) are both true.
- Grant is always one-hot or zero. `sel` always equals the index of the `grant` bit while `valid`=1.

## Timing

- Reset (async, immediate, no clock needed):
  - `grant`=0, `sel`=0, `valid`=0, `preempt`=0, `dout`=0.
  - `ptr`=0, `hcnt`=0, state=IDLE.
- Leaving reset: first rising edge with `rst` low may grant.
- Request-to-grant latency: 1 cycle. `req` sampled at edge n → `grant` valid after edge n+1.
- Release-to-next-grant latency: 1 cycle; back-to-back grants possible.
- `dout` is combinational from `din` through mux16to1, gated by `valid`; no added latency.
- Reset asserted mid-grant: outputs clear asynchronously; pointer history is lost (`ptr`=0).
- Simultaneous requests: the lowest index at or after the search start (wrapping) wins.

## Structure

- Shared package `mux16_pkg`:
  - `N_REQ`=16, `SEL_W`=4, `HCNT_W`=8.
  - State enum {IDLE, GRANT}.
- The existing `mux16to1` is instantiated as the datapath sub-module.
- Winner search is a local function (rotate, priority-encode, un-rotate).

## Test plan

1. Reset: hold `rst`=1 with `req`=16'hFFFF → `grant`=0, `sel`=0, `valid`=0, `dout`=0, `preempt`=0 throughout.
2. Single request: `din`=16'h3f0a, `req`=16'h1000 at edge n → after edge n+1: `grant`=16'h1000, `sel`=4'hc, `valid`=1, `dout`=1. Drop `req` → one cycle later `valid`=0, `dout`=0.
3. Rotation: `MAX_HOLD`=8, `req`=16'hFFFF held → `sel` steps 0,1,…,15,0, each held 8 cycles. `preempt` pulses once per step.
4. Release handoff: `req`=16'h0003 → `sel`=0. Clear bit 0 → next cycle `sel`=1, `valid` stays 1, `preempt`=0.
5. Sole requester: `MAX_HOLD`=8, `req`=16'h0100 for 30 cycles → `sel`=8 throughout, `preempt` never asserted.
6. Async reset mid-grant: `rst` pulsed between edges during a grant on `sel`=5 → outputs zero before the next edge. Then with `rst` low and `req`=16'h0022: first edge after reset release samples `req` in IDLE, and after the following edge `sel`=1 (`ptr` reset to 0).
